// File: rtl/hesap_pkg.sv
// hesap_pkg: shared state encoding and default widths for the BCD converter
//   durum_t          : converter states (BOSTA, MUTLAK, KAYDIR, BITTI)
//   GENISLIK_VARS    : default binary input width
//   BASAMAK_VARS     : default number of BCD digits
//   BASAMAK_GENISLIK : width of one BCD digit
package hesap_pkg;
    typedef enum logic [1:0] {BOSTA, MUTLAK, KAYDIR, BITTI} durum_t;
    localparam int GENISLIK_VARS = 32;
    localparam int BASAMAK_VARS = 10;
    localparam int BASAMAK_GENISLIK = 4;
endpackage

// File: rtl/bcd_basamak_duzelt.sv
// bcd_basamak_duzelt: double-dabble add-3 cell for one BCD digit
//   giris : digit before the shift
//   cikis : digit plus 3 when it is 5 or more, otherwise unchanged
module bcd_basamak_duzelt
    import hesap_pkg::*;
(
    input  logic [BASAMAK_GENISLIK-1:0] giris,
    output logic [BASAMAK_GENISLIK-1:0] cikis
);
    always_comb cikis = (giris >= 4'd5) ? giris + 4'd3 : giris;
endmodule

// File: rtl/bcd_donusturucu.sv
// bcd_donusturucu: captures a signed/unsigned binary result and converts it to sign plus packed BCD
//   clk, rst     : clock and synchronous active-high reset
//   sayi         : binary result, sampled on a rising edge of sayi_hazir
//   sayi_hazir   : upstream ready level
//   sayi_gecerli : upstream valid flag
//   sayi_tasma   : upstream overflow flag
//   basamaklar   : packed BCD, most significant digit in the top nibble
//   isaret       : value is negative
//   hata         : result was invalid or overflowed
//   hazir        : outputs hold a completed conversion
//   mesgul       : conversion in progress
//   kayip        : one-cycle pulse for a ready edge dropped while busy
module bcd_donusturucu
    import hesap_pkg::*;
#(
    parameter int GENISLIK = GENISLIK_VARS,
    parameter int BASAMAK = BASAMAK_VARS,
    parameter bit ISARETLI = 1'b1
)
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [GENISLIK-1:0]                   sayi,
    input  logic                                  sayi_hazir,
    input  logic                                  sayi_gecerli,
    input  logic                                  sayi_tasma,
    output logic [BASAMAK*BASAMAK_GENISLIK-1:0]   basamaklar,
    output logic                                  isaret,
    output logic                                  hata,
    output logic                                  hazir,
    output logic                                  mesgul,
    output logic                                  kayip
);
    localparam int BW = BASAMAK * BASAMAK_GENISLIK;
    localparam int KW = BW + GENISLIK;
    localparam int SW = $clog2(GENISLIK + 1);

    durum_t            durum_q, durum_d;
    logic              onceki_q;
    logic [GENISLIK-1:0] sayi_q, sayi_d;
    logic              gecerli_q, gecerli_d, tasma_q, tasma_d;
    logic              hata_ic_q, hata_ic_d, isaret_ic_q, isaret_ic_d;
    logic [KW-1:0]     kaydirici_q, kaydirici_d, kaydirma;
    logic [SW-1:0]     sayac_q, sayac_d;
    logic [BW-1:0]     basamaklar_q, basamaklar_d, duzelt;
    logic              isaret_q, isaret_d, hata_q, hata_d, hazir_q, hazir_d, kayip_q, kayip_d;
    logic              kenar, negatif, hatali;
    logic [GENISLIK-1:0] mutlak;

    genvar i;
    generate
        for (i = 0; i < BASAMAK; i++) begin : g_duzelt
            bcd_basamak_duzelt u_duzelt (
                .giris(kaydirici_q[GENISLIK+BASAMAK_GENISLIK*i +: BASAMAK_GENISLIK]),
                .cikis(duzelt[BASAMAK_GENISLIK*i +: BASAMAK_GENISLIK])
            );
        end
    endgenerate

    assign kenar = sayi_hazir & ~onceki_q;
    assign hatali = ~gecerli_q | tasma_q;
    assign negatif = ISARETLI & sayi_q[GENISLIK-1];
    // Two's-complement magnitude read as unsigned, so the most negative value fits.
    assign mutlak = negatif ? (~sayi_q) + GENISLIK'(1) : sayi_q;
    assign kaydirma = {duzelt, kaydirici_q[GENISLIK-1:0]};

    always_comb begin
        durum_d = durum_q;
        sayi_d = sayi_q;
        gecerli_d = gecerli_q;
        tasma_d = tasma_q;
        hata_ic_d = hata_ic_q;
        isaret_ic_d = isaret_ic_q;
        kaydirici_d = kaydirici_q;
        sayac_d = sayac_q;
        basamaklar_d = basamaklar_q;
        isaret_d = isaret_q;
        hata_d = hata_q;
        hazir_d = hazir_q;
        kayip_d = kenar & (durum_q != BOSTA);
        case (durum_q)
            BOSTA: if (kenar) begin
                sayi_d = sayi;
                gecerli_d = sayi_gecerli;
                tasma_d = sayi_tasma;
                hazir_d = 1'b0;
                durum_d = MUTLAK;
            end
            MUTLAK: begin
                hata_ic_d = hatali;
                isaret_ic_d = negatif;
                kaydirici_d = {BW'(0), mutlak};
                sayac_d = '0;
                durum_d = hatali ? BITTI : KAYDIR;
            end
            KAYDIR: begin
                kaydirici_d = {kaydirma[KW-2:0], 1'b0};
                sayac_d = sayac_q + SW'(1);
                durum_d = (sayac_q == SW'(GENISLIK - 1)) ? BITTI : KAYDIR;
            end
            default: begin
                basamaklar_d = hata_ic_q ? '0 : kaydirici_q[KW-1:GENISLIK];
                isaret_d = ~hata_ic_q & isaret_ic_q;
                hata_d = hata_ic_q;
                hazir_d = 1'b1;
                durum_d = BOSTA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q <= BOSTA;
            onceki_q <= 1'b1;
            sayi_q <= '0;
            gecerli_q <= 1'b0;
            tasma_q <= 1'b0;
            hata_ic_q <= 1'b0;
            isaret_ic_q <= 1'b0;
            kaydirici_q <= '0;
            sayac_q <= '0;
            basamaklar_q <= '0;
            isaret_q <= 1'b0;
            hata_q <= 1'b0;
            hazir_q <= 1'b0;
            kayip_q <= 1'b0;
        end else begin
            durum_q <= durum_d;
            onceki_q <= sayi_hazir;
            sayi_q <= sayi_d;
            gecerli_q <= gecerli_d;
            tasma_q <= tasma_d;
            hata_ic_q <= hata_ic_d;
            isaret_ic_q <= isaret_ic_d;
            kaydirici_q <= kaydirici_d;
            sayac_q <= sayac_d;
            basamaklar_q <= basamaklar_d;
            isaret_q <= isaret_d;
            hata_q <= hata_d;
            hazir_q <= hazir_d;
            kayip_q <= kayip_d;
        end
    end

    assign basamaklar = basamaklar_q;
    assign isaret = isaret_q;
    assign hata = hata_q;
    assign hazir = hazir_q;
    assign kayip = kayip_q;
    assign mesgul = (durum_q != BOSTA);
endmodule

// File: tb/tb_bcd_donusturucu.sv
// tb_bcd_donusturucu: randomized and directed checks of bcd_donusturucu against a decimal model
module tb_bcd_donusturucu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sayi = '0;
    logic        sayi_hazir = 1'b0, sayi_gecerli = 1'b0, sayi_tasma = 1'b0;
    logic [39:0] basamaklar, basamaklar_u;
    logic        isaret, hata, hazir, mesgul, kayip;
    logic        isaret_u, hata_u, hazir_u, mesgul_u, kayip_u;
    int          gecen = 0, toplam = 0;

    always #5 clk = ~clk;

    bcd_donusturucu dut (
        .clk(clk), .rst(rst), .sayi(sayi), .sayi_hazir(sayi_hazir),
        .sayi_gecerli(sayi_gecerli), .sayi_tasma(sayi_tasma),
        .basamaklar(basamaklar), .isaret(isaret), .hata(hata),
        .hazir(hazir), .mesgul(mesgul), .kayip(kayip)
    );

    bcd_donusturucu #(.ISARETLI(1'b0)) dut_u (
        .clk(clk), .rst(rst), .sayi(sayi), .sayi_hazir(sayi_hazir),
        .sayi_gecerli(sayi_gecerli), .sayi_tasma(sayi_tasma),
        .basamaklar(basamaklar_u), .isaret(isaret_u), .hata(hata_u),
        .hazir(hazir_u), .mesgul(mesgul_u), .kayip(kayip_u)
    );

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) $display("FAIL %s: got %0h expected %0h", etiket, gozlenen, beklenen);
        else gecen++;
    endtask

    function automatic logic [39:0] bcd_model(input longint unsigned m);
        logic [39:0] r;
        for (int d = 0; d < 10; d++) begin
            r[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic saat;
        @(posedge clk);
        #1;
    endtask

    task automatic baslat(input logic [31:0] s, input bit gec, input bit tas);
        sayi = s;
        sayi_gecerli = gec;
        sayi_tasma = tas;
        sayi_hazir = 1'b1;
    endtask

    task automatic bekle(input logic [31:0] s, input bit gec, input bit tas);
        int n = 0;
        bit mesgul_hep = 1'b1;
        bit err = !gec || tas;
        longint v = longint'($signed(s));
        bit neg = v < 0;
        longint unsigned mag = neg ? -v : v;
        longint unsigned uval = {32'h0, s};
        do begin
            saat();
            n++;
            if (!hazir && !mesgul) mesgul_hep = 1'b0;
        end while (!hazir && n < 100);
        kontrol("gecikme", n, err ? 3 : 35);
        kontrol("mesgul_boyunca", mesgul_hep, 1);
        kontrol("mesgul_son", mesgul, 0);
        kontrol("basamaklar", basamaklar, err ? 40'h0 : bcd_model(mag));
        kontrol("isaret", isaret, err ? 1'b0 : neg);
        kontrol("hata", hata, err);
        kontrol("hazir_u", hazir_u, 1);
        kontrol("basamaklar_u", basamaklar_u, err ? 40'h0 : bcd_model(uval));
        kontrol("isaret_u", isaret_u, 0);
        kontrol("hata_u", hata_u, err);
    endtask

    task automatic donustur(input logic [31:0] s, input bit gec, input bit tas);
        baslat(s, gec, tas);
        bekle(s, gec, tas);
        sayi_hazir = 1'b0;
        saat();
    endtask

    initial begin
        int n;
        bit ok;
        repeat (3) saat();
        kontrol("reset_cikis", {basamaklar, isaret, hata, hazir, mesgul, kayip}, 0);
        rst = 1'b0;
        saat();

        donustur(32'd12345, 1, 0);
        kontrol("12345_sabit", basamaklar, 40'h0000012345);
        donustur(32'hFFFFFFF6, 1, 0);
        kontrol("eksi10_sabit", {basamaklar, isaret}, {40'h0000000010, 1'b1});
        donustur(32'h80000000, 1, 0);
        kontrol("enkucuk_sabit", {basamaklar, isaret}, {40'h2147483648, 1'b1});
        donustur(32'hFFFFFFFF, 1, 0);
        kontrol("isaretsiz_enbuyuk", {basamaklar_u, isaret_u}, {40'h4294967295, 1'b0});
        donustur(32'd0, 1, 0);
        donustur(32'd77, 1, 1);
        kontrol("tasma_hata", {hata, basamaklar, isaret}, {1'b1, 40'h0, 1'b0});
        donustur(32'hFFFFFF00, 0, 0);
        kontrol("gecersiz_hata", {hata, basamaklar}, {1'b1, 40'h0});

        for (int t = 0; t < 24; t++) begin
            logic [31:0] s;
            bit gec = 1'b1, tas = 1'b0;
            case ($urandom_range(0, 3))
                0: s = $urandom;
                1: s = $urandom_range(0, 9999);
                2: s = -$urandom_range(1, 100000);
                default: begin
                    s = $urandom;
                    gec = 1'($urandom_range(0, 1));
                    tas = 1'($urandom_range(0, 1));
                end
            endcase
            donustur(s, gec, tas);
        end

        // Edge while shifting is dropped; first-cycle edge after hazir is accepted.
        baslat(32'd999, 1, 0);
        repeat (2) saat();
        sayi_hazir = 1'b0;
        repeat (9) saat();
        sayi = 32'd777;
        sayi_hazir = 1'b1;
        saat();
        kontrol("kayip_darbe", kayip, 1);
        sayi_hazir = 1'b0;
        saat();
        kontrol("kayip_tek", kayip, 0);
        n = 0;
        while (!hazir && n < 60) begin
            saat();
            n++;
        end
        kontrol("carpisma_sonuc", basamaklar, 40'h0000000999);
        baslat(32'd4321, 1, 0);
        bekle(32'd4321, 1, 0);
        kontrol("ilk_bosta_kabul", basamaklar, 40'h0000004321);
        sayi_hazir = 1'b0;
        saat();

        // Edge landing on the BITTI cycle is dropped.
        baslat(32'd55, 1, 0);
        for (int c = 1; c <= 34; c++) begin
            saat();
            if (c == 1) sayi_hazir = 1'b0;
        end
        kontrol("bitti_oncesi", {mesgul, hazir}, 2'b10);
        sayi_hazir = 1'b1;
        saat();
        kontrol("bitti_kayip", {hazir, kayip}, 2'b11);
        kontrol("bitti_sonuc", basamaklar, 40'h0000000055);
        saat();
        kontrol("bitti_bosta", {mesgul, kayip}, 2'b00);
        sayi_hazir = 1'b0;
        saat();

        // Reset in mid-conversion, ready held high through release.
        baslat(32'd12345, 1, 0);
        repeat (12) saat();
        kontrol("iptal_oncesi_mesgul", mesgul, 1);
        rst = 1'b1;
        saat();
        kontrol("iptal_cikis", {basamaklar, isaret, hata, hazir, mesgul, kayip}, 0);
        saat();
        rst = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            saat();
            if (mesgul || hazir) ok = 1'b0;
        end
        kontrol("reset_sonrasi_kenar_yok", ok, 1);
        sayi_hazir = 1'b0;
        saat();
        donustur(32'd12345, 1, 0);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end
endmodule

// File: doc/bcd_donusturucu.md
Name: bcd_donusturucu

Overview:
- Downstream stage of the calculator arithmetic units (add, subtract, and so on).
- Captures a finished result when the unit's `hazir` level rises, and converts the signed 32-bit result into sign plus 10 packed BCD digits for the display driver.
- Conversion is a sequential double-dabble, one bit per clock.
- Flags an error instead of converting when the result is invalid or overflowed.

Parameters:
- GENISLIK, 32: width of the binary input.
- BASAMAK, 10: number of BCD digits output. Must be at least ceil(GENISLIK·log10(2)).
- ISARETLI, 1: 1 means the input is two's-complement; 0 means unsigned.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sayi  in  GENISLIK  result from the arithmetic unit (its sonuc[GENISLIK-1:0]); stable while sayi_hazir is high.
- sayi_hazir  in  1  upstream ready level; a rising edge marks a new result.
- sayi_gecerli  in  1  upstream valid flag, sampled with sayi.
- sayi_tasma  in  1  upstream overflow flag, sampled with sayi.
- basamaklar  out  4·BASAMAK  packed BCD; the most significant digit is in the top nibble.
- isaret  out  1  1 means the value is negative.
- hata  out  1  1 means the result is invalid or overflowed.
- hazir  out  1  basamaklar, isaret and hata hold a completed conversion.
- mesgul  out  1  a conversion is in progress.
- kayip  out  1  one-cycle pulse: a rising edge arrived while busy and was dropped.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - basamaklar=0, isaret=0, hata=0, hazir=0, mesgul=0, kayip=0, state=BOSTA, counter=0.
  - The edge-detect register is set to 1, so a sayi_hazir held high after reset is not an edge.
  - rst asserted mid-conversion aborts it immediately, with the same values.
- Edge detect: `onceki` is a register of sayi_hazir. An edge is `sayi_hazir & ~onceki`.
- States:
  - BOSTA:
    - On an edge, register sayi, sayi_gecerli and sayi_tasma; hazir<=0; go to MUTLAK.
    - Outputs keep their previous values until BITTI.
  - MUTLAK:
    - If the captured gecerli=0 or tasma=1: set the error marker and go directly to BITTI.
    - Otherwise:
      - If ISARETLI and the MSB is 1: isaret_ic=1 and magnitude = ~sayi+1, taken as unsigned GENISLIK bits. 0x80000000 gives 2147483648; no overflow is possible.
      - Else isaret_ic=0 and magnitude = sayi.
      - Load the shift register with {BASAMAK×4'h0, magnitude}; counter<=0; go to KAYDIR.
  - KAYDIR:
    - Each cycle, every BCD digit ≥5 gets +3 (combinational), then the whole register shifts left by 1.
    - counter increments each cycle.
    - On the cycle where counter==GENISLIK-1, go to BITTI. That is exactly GENISLIK shift cycles.
  - BITTI:
    - Normal case: basamaklar<=BCD field, isaret<=isaret_ic, hata<=0.
    - Error case: basamaklar<=0, isaret<=0, hata<=1.
    - hazir<=1; go to BOSTA.
- mesgul = (state != BOSTA).
- Latency, with edge sampled at clock edge k:
  - Normal: outputs and hazir update at edge k+GENISLIK+2 (k+34 at the defaults).
  - Error path: outputs and hazir update at edge k+2.
- Busy collision: an edge seen while state≠BOSTA is dropped, and kayip=1 for that one cycle. The current conversion is unaffected.
- Back-to-back: an edge in the same cycle that BITTI returns to BOSTA is dropped (kayip pulse), because the state is still ≠BOSTA when it is sampled. An edge on the first BOSTA cycle is accepted.
- Zero input gives basamaklar=0, isaret=0.
- Negative zero cannot occur.

Decomposition:
- Shared package `hesap_pkg`:
  - state enum (BOSTA, MUTLAK, KAYDIR, BITTI);
  - default constants GENISLIK=32 and BASAMAK=10;
  - the BCD digit width constant, 4.
- One sub-module: `bcd_basamak_duzelt`. It is the combinational add-3 cell (4-bit in, 4-bit out: ≥5 gives +3), instantiated BASAMAK times by a generate loop.

Test Plan:
- sayi=32'd12345, gecerli=1, tasma=0, edge at k → hazir=1 at k+34, basamaklar=40'h0000012345, isaret=0, hata=0; mesgul high for cycles k+1..k+34.
- sayi=32'hFFFFFFF6 (−10) → basamaklar=40'h0000000010, isaret=1, hata=0.
- sayi=32'h80000000 → basamaklar=40'h2147483648, isaret=1. With ISARETLI=0 and sayi=32'hFFFFFFFF → 40'h4294967295, isaret=0.
- sayi_tasma=1 (any sayi) → hazir at k+2, hata=1, basamaklar=0, isaret=0. Also with sayi_gecerli=0 → same.
- Second sayi_hazir edge 10 cycles into a conversion of 32'd999 → kayip pulses for 1 cycle; final basamaklar=40'h0000000999. An edge on the first cycle after hazir rises is accepted.
- rst at shift cycle 10 → next cycle all outputs 0 and mesgul=0. sayi_hazir held high through reset release gives no conversion; a subsequent low-to-high edge of sayi_hazir converts normally.
